instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Program-counter and fetch stage that drives the 16-bit address of the combinational instruction ROM.
//  Registers the returned 28-bit instruction into an instruction register (IR) and splits it into fields for the decode/execute stage.
//  Supports stall from downstream, branch/jump redirect, start/stop enable and a saturating fetch counter.
// PARAMETERS
//  RESET_PC   16'd0   PC value loaded on reset
//  ADDR_W     16      address width (PC, ROM address, branch target)
//  INSTR_W    28      instruction width (opcode[27:24], dest[23:16], src1[15:8], src0[7:0], imm[15:0])
// PORTS
//  Clock          in   1        system clock, rising edge
//  Reset          in   1        asynchronous reset, active-high
//  iEnable        in   1        1 = run fetch; 0 = return to/stay in IDLE
//  iStall         in   1        downstream not ready; hold IR and PC
//  iBranchTaken   in   1        redirect request (single-cycle pulse)
//  iBranchTarget  in   ADDR_W   new PC when iBranchTaken=1
//  oAddress       out  ADDR_W   ROM address (= PC, combinational)
//  iInstruction   in   INSTR_W  ROM data for oAddress, same cycle
//  oInstruction   out  INSTR_W  IR contents
//  oOpcode        out  4        IR[27:24]
//  oDest          out  8        IR[23:16]
//  oSrc1          out  8        IR[15:8]
//  oSrc0          out  8        IR[7:0]
//  oImm           out  16       IR[15:0]
//  oPC            out  ADDR_W   address the IR was fetched from
//  oValid         out  1        IR holds a valid instruction
//  oFetchCount    out  16       number of IR loads, saturating
// BEHAVIOUR
//  Reset (async, any state): PC=RESET_PC, state=IDLE, IR=0, oPC=0, oValid=0, oFetchCount=0.
//  Field outputs are pure slices of IR; oAddress=PC (no register between PC and ROM).
//  FSM states: IDLE, FETCH, HOLD. Priority each cycle: iBranchTaken > ~iEnable > iStall > normal fetch.
//  IDLE: oValid<=0, PC holds; iEnable=1 -> FETCH next cycle (first fetch uses current PC).
//   iBranchTaken in IDLE: PC<=iBranchTarget, stay IDLE.
//  FETCH (normal): IR<=iInstruction, oPC<=PC, oValid<=1, PC<=PC+1 (16'hFFFF wraps to 0), count++.
//   Latency: instruction at address A appears on oInstruction 1 clock after oAddress==A.
//  FETCH/HOLD + iBranchTaken: PC<=iBranchTarget, oValid<=0 (one-cycle bubble, in-flight IR flushed), state=FETCH;
//   the next cycle fetches the target. Branch overrides a simultaneous iStall.
//  FETCH/HOLD + iEnable=0 (no branch): oValid<=0, PC holds, state=IDLE.
//  FETCH + iStall=1: IR, oPC, oValid, PC, count all hold; state=HOLD.
//  HOLD: holds while iStall=1; iStall=0 -> performs a normal fetch this cycle and goes to FETCH.
//  oFetchCount: +1 on every IR load, saturates at 16'hFFFF (no wrap); not cleared by branch or IDLE.
//  No X propagation: IR loads only in a normal-fetch cycle; otherwise all registers hold their values.
// TESTING
//  1 Reset then iEnable=1, ROM[0..3]=distinct words -> oAddress 0,1,2,3 on consecutive cycles;
//    oInstruction=ROM[n] with oPC=n and oValid=1 one cycle later; oFetchCount=4 after 4 loads.
//  2 iStall high for 3 cycles while PC=5 -> oAddress stays 5, IR/oPC=4 held, oValid stays 1;
//    after release oPC=5 on the next cycle.
//  3 iBranchTaken=1, iBranchTarget=16'd0 at PC=7 (models JMP 0) -> next cycle oValid=0 and oAddress=0;
//    the cycle after, oInstruction=ROM[0] and oPC=0.
//  4 Branch and stall asserted together -> branch wins: PC=target, bubble, fetch resumes next cycle.
//  5 Preset PC to 16'hFFFE via a branch, run -> fetches FFFE, FFFF, then 0000 (wrap).
//    oFetchCount forced near FFFF saturates at FFFF.
//  6 Assert Reset asynchronously mid-FETCH (between clock edges) -> all outputs return to reset values immediately;
//    state=IDLE; after Reset drops and iEnable=1, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the program counter, addresses the combinational
// instruction ROM, captures the returned word into the instruction register
// and exposes its fields to decode. Handles stall, redirect, enable and a
// saturating count of instruction-register loads.
module instruction_fetch_unit #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned INSTR_W  = 28,
    parameter logic [15:0] RESET_PC = 16'd0
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iEnable,
    input  logic               iStall,
    input  logic               iBranchTaken,
    input  logic [ADDR_W-1:0]  iBranchTarget,
    output logic [ADDR_W-1:0]  oAddress,
    input  logic [INSTR_W-1:0] iInstruction,
    output logic [INSTR_W-1:0] oInstruction,
    output logic [3:0]         oOpcode,
    output logic [7:0]         oDest,
    output logic [7:0]         oSrc1,
    output logic [7:0]         oSrc0,
    output logic [15:0]        oImm,
    output logic [ADDR_W-1:0]  oPC,
    output logic               oValid,
    output logic [15:0]        oFetchCount
);

    localparam int unsigned COUNT_W = 16;
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [ADDR_W-1:0]    pc, pc_next;
    logic [INSTR_W-1:0]   ir, ir_next;
    logic [ADDR_W-1:0]    fetch_pc, fetch_pc_next;
    logic                 valid, valid_next;
    logic [COUNT_W-1:0]   fetch_count, fetch_count_next;

    // State and datapath registers; reset clears everything except PC, which
    // restarts at the configured boot address.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            pc          <= ADDR_W'(RESET_PC);
            ir          <= '0;
            fetch_pc    <= '0;
            valid       <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            ir          <= ir_next;
            fetch_pc    <= fetch_pc_next;
            valid       <= valid_next;
            fetch_count <= fetch_count_next;
        end
    end

    // Next-state and datapath control; priority is redirect, then disable,
    // then stall, then a normal fetch. Anything not explicitly loaded holds.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        ir_next          = ir;
        fetch_pc_next    = fetch_pc;
        valid_next       = valid;
        fetch_count_next = fetch_count;

        case (state)
            IDLE: begin
                valid_next = 1'b0;
                if (iBranchTaken) begin
                    pc_next = iBranchTarget;
                end else if (iEnable) begin
                    state_next = FETCH;
                end
            end

            FETCH, HOLD: begin
                if (iBranchTaken) begin
                    // Flush the in-flight word; the target is fetched next cycle.
                    pc_next    = iBranchTarget;
                    valid_next = 1'b0;
                    state_next = FETCH;
                end else if (!iEnable) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end else if (iStall) begin
                    state_next = HOLD;
                end else begin
                    ir_next          = iInstruction;
                    fetch_pc_next    = pc;
                    valid_next       = 1'b1;
                    pc_next          = pc + ADDR_W'(1);
                    fetch_count_next = (fetch_count == COUNT_MAX)
                                       ? fetch_count
                                       : fetch_count + COUNT_W'(1);
                    state_next       = FETCH;
                end
            end

            default: begin
                valid_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // ROM address is the live PC; decode fields are plain slices of IR.
    assign oAddress     = pc;
    assign oInstruction = ir;
    assign oOpcode      = ir[INSTR_W-1 -: 4];
    assign oDest        = ir[INSTR_W-5 -: 8];
    assign oSrc1        = ir[15:8];
    assign oSrc0        = ir[7:0];
    assign oImm         = ir[15:0];
    assign oPC          = fetch_pc;
    assign oValid       = valid;
    assign oFetchCount  = fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for the fetch stage with a behavioural combinational ROM.
module tb_instruction_fetch_unit;

    logic        Clock;
    logic        Reset;
    logic        iEnable;
    logic        iStall;
    logic        iBranchTaken;
    logic [15:0] iBranchTarget;
    logic [15:0] oAddress;
    logic [27:0] iInstruction;
    logic [27:0] oInstruction;
    logic [3:0]  oOpcode;
    logic [7:0]  oDest;
    logic [7:0]  oSrc1;
    logic [7:0]  oSrc0;
    logic [15:0] oImm;
    logic [15:0] oPC;
    logic        oValid;
    logic [15:0] oFetchCount;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch_unit #(
        .ADDR_W  (16),
        .INSTR_W (28),
        .RESET_PC(16'd0)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iEnable      (iEnable),
        .iStall       (iStall),
        .iBranchTaken (iBranchTaken),
        .iBranchTarget(iBranchTarget),
        .oAddress     (oAddress),
        .iInstruction (iInstruction),
        .oInstruction (oInstruction),
        .oOpcode      (oOpcode),
        .oDest        (oDest),
        .oSrc1        (oSrc1),
        .oSrc0        (oSrc0),
        .oImm         (oImm),
        .oPC          (oPC),
        .oValid       (oValid),
        .oFetchCount  (oFetchCount)
    );

    // Distinct word per address so any mis-addressed fetch is visible.
    function automatic logic [27:0] rom_word(input logic [15:0] a);
        return {a[3:0] ^ 4'h9, a[7:0] ^ 8'h5A, a ^ 16'h1234};
    endfunction

    assign iInstruction = rom_word(oAddress);

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, " valid"}, 32'(oValid), 32'd0);
        check_eq({tag, " addr"},  32'(oAddress), 32'd0);
        check_eq({tag, " ir"},    32'(oInstruction), 32'd0);
        check_eq({tag, " pc"},    32'(oPC), 32'd0);
        check_eq({tag, " count"}, 32'(oFetchCount), 32'd0);
    endtask

    logic [27:0] exp_word;

    initial begin
        Reset = 1'b1; iEnable = 1'b0; iStall = 1'b0;
        iBranchTaken = 1'b0; iBranchTarget = 16'd0;
        step(); step();
        Reset = 1'b0;
        check_reset_values("reset");

        // Sequential fetch of addresses 0..3
        iEnable = 1'b1;
        step();
        check_eq("idle->fetch addr", 32'(oAddress), 32'd0);
        check_eq("idle->fetch valid", 32'(oValid), 32'd0);
        for (int n = 0; n < 4; n++) begin
            step();
            check_eq("seq ir", 32'(oInstruction), 32'(rom_word(16'(n))));
            check_eq("seq pc", 32'(oPC), 32'(n));
            check_eq("seq valid", 32'(oValid), 32'd1);
            check_eq("seq addr", 32'(oAddress), 32'(n + 1));
        end
        check_eq("seq count", 32'(oFetchCount), 32'd4);

        // Stall with PC=5
        step();
        check_eq("pre-stall addr", 32'(oAddress), 32'd5);
        iStall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("stall addr", 32'(oAddress), 32'd5);
            check_eq("stall pc", 32'(oPC), 32'd4);
            check_eq("stall ir", 32'(oInstruction), 32'(rom_word(16'd4)));
            check_eq("stall valid", 32'(oValid), 32'd1);
            check_eq("stall count", 32'(oFetchCount), 32'd5);
        end
        iStall = 1'b0;
        step();
        exp_word = rom_word(16'd5);
        check_eq("release pc", 32'(oPC), 32'd5);
        check_eq("release count", 32'(oFetchCount), 32'd6);
        check_eq("field opcode", 32'(oOpcode), 32'(exp_word[27:24]));
        check_eq("field dest", 32'(oDest), 32'(exp_word[23:16]));
        check_eq("field src1", 32'(oSrc1), 32'(exp_word[15:8]));
        check_eq("field src0", 32'(oSrc0), 32'(exp_word[7:0]));
        check_eq("field imm", 32'(oImm), 32'(exp_word[15:0]));

        // Jump to 0 at PC=7
        step();
        check_eq("pre-jmp addr", 32'(oAddress), 32'd7);
        iBranchTaken = 1'b1; iBranchTarget = 16'd0;
        step();
        iBranchTaken = 1'b0;
        check_eq("jmp bubble valid", 32'(oValid), 32'd0);
        check_eq("jmp addr", 32'(oAddress), 32'd0);
        check_eq("jmp count held", 32'(oFetchCount), 32'd7);
        step();
        check_eq("jmp ir", 32'(oInstruction), 32'(rom_word(16'd0)));
        check_eq("jmp pc", 32'(oPC), 32'd0);
        check_eq("jmp valid", 32'(oValid), 32'd1);
        check_eq("jmp count", 32'(oFetchCount), 32'd8);

        // Branch together with stall: branch wins
        iBranchTaken = 1'b1; iBranchTarget = 16'h0040; iStall = 1'b1;
        step();
        iBranchTaken = 1'b0; iStall = 1'b0;
        check_eq("br+stall addr", 32'(oAddress), 32'h40);
        check_eq("br+stall valid", 32'(oValid), 32'd0);
        step();
        check_eq("br+stall pc", 32'(oPC), 32'h40);
        check_eq("br+stall ir", 32'(oInstruction), 32'(rom_word(16'h0040)));
        check_eq("br+stall count", 32'(oFetchCount), 32'd9);

        // Disable, then redirect while idle, then re-enable
        iEnable = 1'b0;
        step();
        check_eq("disable valid", 32'(oValid), 32'd0);
        check_eq("disable addr", 32'(oAddress), 32'h41);
        step();
        check_eq("idle addr", 32'(oAddress), 32'h41);
        check_eq("idle count", 32'(oFetchCount), 32'd9);
        iBranchTaken = 1'b1; iBranchTarget = 16'h0100;
        step();
        iBranchTaken = 1'b0;
        check_eq("idle br addr", 32'(oAddress), 32'h100);
        check_eq("idle br valid", 32'(oValid), 32'd0);
        iEnable = 1'b1;
        step();
        check_eq("reenable valid", 32'(oValid), 32'd0);
        step();
        check_eq("reenable pc", 32'(oPC), 32'h100);
        check_eq("reenable count", 32'(oFetchCount), 32'd10);

        // PC wrap from FFFF to 0000
        iBranchTaken = 1'b1; iBranchTarget = 16'hFFFE;
        step();
        iBranchTaken = 1'b0;
        check_eq("wrap start addr", 32'(oAddress), 32'hFFFE);
        step();
        check_eq("wrap pc0", 32'(oPC), 32'hFFFE);
        check_eq("wrap addr0", 32'(oAddress), 32'hFFFF);
        step();
        check_eq("wrap pc1", 32'(oPC), 32'hFFFF);
        check_eq("wrap addr1", 32'(oAddress), 32'h0000);
        step();
        check_eq("wrap pc2", 32'(oPC), 32'h0000);
        check_eq("wrap count", 32'(oFetchCount), 32'd13);

        // Run the counter into saturation
        repeat (65522) @(posedge Clock);
        #1;
        check_eq("sat reach", 32'(oFetchCount), 32'hFFFF);
        check_eq("sat addr", 32'(oAddress), 32'hFFF3);
        step(); step(); step();
        check_eq("sat hold", 32'(oFetchCount), 32'hFFFF);
        check_eq("sat pc advance", 32'(oAddress), 32'hFFF6);
        check_eq("sat valid", 32'(oValid), 32'd1);

        // Asynchronous reset between clock edges
        #2;
        Reset = 1'b1;
        #1;
        check_reset_values("async reset");
        step();
        Reset = 1'b0;
        check_reset_values("post reset");
        step();
        check_eq("restart addr", 32'(oAddress), 32'd0);
        check_eq("restart valid0", 32'(oValid), 32'd0);
        step();
        check_eq("restart pc", 32'(oPC), 32'd0);
        check_eq("restart ir", 32'(oInstruction), 32'(rom_word(16'd0)));
        check_eq("restart valid", 32'(oValid), 32'd1);
        check_eq("restart count", 32'(oFetchCount), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
